// File: rtl/serial_tx_arbiter_if.sv
// Bundle between the requesters, the arbiter and the serial sender.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready toward requesters; sender_enable/sender_ack toward the sender.
interface serial_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int PKT_W = 42,
    parameter int PAD_W = 4
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*PKT_W-1:0] req_packet;
    logic [N_REQ*PAD_W-1:0] req_padding;
    logic [N_REQ-1:0]       req_ready;
    logic [PKT_W-1:0]       sender_packet;
    logic [PAD_W-1:0]       sender_padding;
    logic                   sender_enable;
    logic                   sender_ack;
    logic                   flush;
    logic                   busy;
    logic [ID_W-1:0]        cur_id;
    logic [7:0]             drop_cnt;

    // Arbiter side: consumes requests and link status, drives the sender.
    modport slave (
        input  req_valid, req_packet, req_padding, sender_ack, flush,
        output req_ready, sender_packet, sender_padding, sender_enable,
               busy, cur_id, drop_cnt
    );

    // Environment side: requesters plus the serial sender.
    modport master (
        output req_valid, req_packet, req_padding, sender_ack, flush,
        input  req_ready, sender_packet, sender_padding, sender_enable,
               busy, cur_id, drop_cnt
    );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial sender among N_REQ requesters; holds the winner's packet.
// Latency: grant is combinational in IDLE, sender_enable rises on the grant edge, falls on the ack edge.
// Backpressure: one packet in flight; req_ready pulses only in IDLE. Optional macro SERIAL_TX_ARB_RETRY_EN retransmits on flush.
module serial_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int PKT_W     = 42,
    parameter int PAD_W     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic clk,
    input  logic rst,
    serial_tx_arbiter_if.slave bus
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1
`ifdef SERIAL_TX_ARB_RETRY_EN
        ,
        BACKOFF = 2'd2
`endif
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   id_q;
    logic [PKT_W-1:0]  pkt_q;
    logic [PAD_W-1:0]  pad_q;
    logic [7:0]        drop_q;
    logic              pick_vld;
    logic [ID_W-1:0]   pick_id;
    logic              grant;
    logic              drop;

`ifdef SERIAL_TX_ARB_RETRY_EN
    localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RC_W-1:0]   retry_q;
    logic              retry_inc;
`endif

    // Round-robin search starting just after the last winner.
    always_comb begin : rr_pick
        int idx;
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (!pick_vld && bus.req_valid[idx]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(idx);
            end
        end
    end

    // Next-state logic; ack has priority over a simultaneous flush.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        drop    = 1'b0;
`ifdef SERIAL_TX_ARB_RETRY_EN
        retry_inc = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.sender_ack) begin
                    state_d = IDLE;
                end else if (bus.flush) begin
`ifdef SERIAL_TX_ARB_RETRY_EN
                    if (retry_q == RC_W'(MAX_RETRY)) begin
                        drop    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        retry_inc = 1'b1;
                        state_d   = BACKOFF;
                    end
`else
                    drop    = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
`ifdef SERIAL_TX_ARB_RETRY_EN
            BACKOFF: state_d = SEND;
`endif
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops sender_enable immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Holding register and round-robin pointer, loaded only on a grant edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= ID_W'(N_REQ - 1);
            id_q   <= '0;
            pkt_q  <= '0;
            pad_q  <= '0;
        end else if (grant) begin
            last_q <= pick_id;
            id_q   <= pick_id;
            pkt_q  <= bus.req_packet[int'(pick_id)*PKT_W +: PKT_W];
            pad_q  <= bus.req_padding[int'(pick_id)*PAD_W +: PAD_W];
        end
    end

    // Saturating count of packets abandoned because of a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          drop_q <= '0;
        else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end

`ifdef SERIAL_TX_ARB_RETRY_EN
    // Retransmission count for the held packet; restarts on every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            retry_q <= '0;
        else if (grant)     retry_q <= '0;
        else if (retry_inc) retry_q <= retry_q + 1'b1;
    end
`endif

    // Ready is masked during reset so it reads 0 even with requests pending.
    assign bus.req_ready      = (grant && !rst) ? (N_REQ'(1) << pick_id) : '0;
    assign bus.sender_enable  = (state_q == SEND);
    assign bus.busy           = (state_q != IDLE);
    assign bus.sender_packet  = pkt_q;
    assign bus.sender_padding = pad_q;
    assign bus.cur_id         = id_q;
    assign bus.drop_cnt       = drop_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: reset, single grant, round-robin, ack/flush, saturation, async reset.
// Inputs change and outputs are sampled on the falling edge.
// Works with or without SERIAL_TX_ARB_RETRY_EN defined.
module tb_serial_tx_arbiter;
    localparam int N = 4;
    localparam int PW = 42;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_tx_arbiter_if #(.N_REQ(N), .PKT_W(PW), .PAD_W(DW)) bus ();

    serial_tx_arbiter #(.N_REQ(N), .PKT_W(PW), .PAD_W(DW), .MAX_RETRY(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Grant requester id, then flush until the packet is dropped.
    task automatic drop_one(input int id);
        bit done;
        done = 1'b0;
        bus.req_valid = 4'(1 << id);
        tick();
        bus.req_valid = '0;
        for (int k = 0; k < 12 && !done; k++) begin
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
            if (!bus.busy) done = 1'b1;
            else tick();
        end
        if (!done) chk("drop_timeout", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0] pkt2;
        logic [PW-1:0] first_pkt;
        int            exp_order [5];
        bit            stable;

        exp_order = '{0, 1, 2, 3, 0};
        pkt2 = 42'h24c65316459;

        bus.req_valid   = 4'b1111;
        bus.req_packet  = '0;
        bus.req_padding = '0;
        bus.sender_ack  = 1'b0;
        bus.flush       = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.req_packet[i*PW +: PW]  = 42'h3a0_0000_0100 + 42'(i);
            bus.req_padding[i*DW +: DW] = 4'(i + 4);
        end

        // Reset values, with every request pending
        tick();
        tick();
        chk("rst_ready",  64'(bus.req_ready), 64'd0);
        chk("rst_enable", 64'(bus.sender_enable), 64'd0);
        chk("rst_busy",   64'(bus.busy), 64'd0);
        chk("rst_drop",   64'(bus.drop_cnt), 64'd0);
        chk("rst_id",     64'(bus.cur_id), 64'd0);
        chk("rst_pkt",    64'(bus.sender_packet), 64'd0);
        chk("rst_pad",    64'(bus.sender_padding), 64'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

        // Single request from requester 2
        bus.req_packet[2*PW +: PW]  = pkt2;
        bus.req_padding[2*DW +: DW] = 4'b1011;
        bus.req_valid = 4'b0100;
        #1;
        chk("single_ready", 64'(bus.req_ready), 64'h4);
        chk("single_en_pre", 64'(bus.sender_enable), 64'd0);
        tick();
        chk("single_ready_pulse", 64'(bus.req_ready), 64'd0);
        chk("single_en", 64'(bus.sender_enable), 64'd1);
        chk("single_pkt", 64'(bus.sender_packet), 64'(pkt2));
        chk("single_pad", 64'(bus.sender_padding), 64'hb);
        chk("single_id", 64'(bus.cur_id), 64'd2);
        bus.req_valid = '0;
        bus.req_packet[2*PW +: PW] = 42'h155_5555_5555;
        stable = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (bus.sender_enable !== 1'b1 || bus.sender_packet !== pkt2 ||
                bus.sender_padding !== 4'b1011) stable = 1'b0;
        end
        chk("single_stable", 64'(stable), 64'd1);
        bus.sender_ack = 1'b1;
        tick();
        bus.sender_ack = 1'b0;
        chk("single_en_after_ack", 64'(bus.sender_enable), 64'd0);
        chk("single_busy_after_ack", 64'(bus.busy), 64'd0);
        chk("single_pkt_hold", 64'(bus.sender_packet), 64'(pkt2));

        // Round-robin from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req_packet[2*PW +: PW] = 42'h3a0_0000_0102;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_grant", 64'(bus.req_ready), 64'(1 << exp_order[i]));
            chk("rr_idle_gap", 64'(bus.sender_enable), 64'd0);
            tick();
            chk("rr_pulse", 64'(bus.req_ready), 64'd0);
            chk("rr_id", 64'(bus.cur_id), 64'(exp_order[i]));
            chk("rr_pkt", 64'(bus.sender_packet), 64'h3a0_0000_0100 + 64'(exp_order[i]));
            tick();
            bus.sender_ack = 1'b1;
            tick();
            bus.sender_ack = 1'b0;
            if (i == 4) bus.req_valid = '0;
        end

        // Ack and flush together: delivered, not dropped
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        bus.sender_ack = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.sender_ack = 1'b0;
        bus.flush = 1'b0;
        chk("ackflush_en", 64'(bus.sender_enable), 64'd0);
        chk("ackflush_drop", 64'(bus.drop_cnt), 64'd0);
        tick();
        chk("ackflush_no_resend", 64'(bus.busy), 64'd0);

        // Ack and flush while idle are ignored
        bus.sender_ack = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.sender_ack = 1'b0;
        bus.flush = 1'b0;
        chk("idle_ignore_drop", 64'(bus.drop_cnt), 64'd0);
        chk("idle_ignore_busy", 64'(bus.busy), 64'd0);

        // Flush during SEND; requester 1 wins (last was 0), requester 2 waits
        bus.req_valid = 4'b0110;
        #1;
        chk("flush_grant", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 4'b0100;
        first_pkt = bus.sender_packet;
        chk("flush_pkt", 64'(first_pkt), 64'h3a0_0000_0101);
`ifdef SERIAL_TX_ARB_RETRY_EN
        for (int r = 0; r < 3; r++) begin
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
            chk("retry_backoff_en", 64'(bus.sender_enable), 64'd0);
            chk("retry_backoff_busy", 64'(bus.busy), 64'd1);
            tick();
            chk("retry_resend_en", 64'(bus.sender_enable), 64'd1);
            chk("retry_resend_pkt", 64'(bus.sender_packet), 64'(first_pkt));
        end
`endif
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_en", 64'(bus.sender_enable), 64'd0);
        chk("flush_drop", 64'(bus.drop_cnt), 64'd1);
        chk("flush_busy", 64'(bus.busy), 64'd0);
        #1;
        chk("flush_next_grant", 64'(bus.req_ready), 64'h4);
        tick();
        bus.req_valid = '0;
        chk("flush_next_id", 64'(bus.cur_id), 64'd2);
        chk("flush_next_en", 64'(bus.sender_enable), 64'd1);
        bus.sender_ack = 1'b1;
        tick();
        bus.sender_ack = 1'b0;

        // Drop counter saturates at 255
        for (int d = 0; d < 256; d++) drop_one(d % N);
        chk("drop_saturate", 64'(bus.drop_cnt), 64'd255);

        // Asynchronous reset in the middle of SEND
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        chk("midrst_pre_en", 64'(bus.sender_enable), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_en", 64'(bus.sender_enable), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_drop", 64'(bus.drop_cnt), 64'd0);
        chk("midrst_pkt", 64'(bus.sender_packet), 64'd0);
        chk("midrst_id", 64'(bus.cur_id), 64'd0);
        tick();
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        chk("midrst_first_grant", 64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = '0;
        bus.sender_ack = 1'b1;
        tick();
        bus.sender_ack = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
